// File: rtl/ibuffer_rd_burst_gen_pkg.sv
// Shared constants and FSM state type for the input-buffer read path.
// No logic; constants only.
// No flow control; constants only.
package ibuf_pkg;

  localparam int IBUF_ADDR_W          = 15;
  localparam int IBUF_DATA_W          = 128;
  localparam int IBUF_DEPTH           = 24576;
  localparam int IBUF_LEN_W           = 16;
  localparam int IBUF_MAX_OUTSTANDING = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } ibuf_rd_state_e;

endpackage

// File: rtl/ibuffer_rd_burst_gen_if.sv
// Descriptor, buffer port-a and output-stream signals of the burst read master.
// Pure wiring, no latency.
// Carries valid/ready on descriptor, request, return and output stream.
interface ibuffer_rd_burst_gen_if #(
  parameter int ADDR_W = ibuf_pkg::IBUF_ADDR_W,
  parameter int DATA_W = ibuf_pkg::IBUF_DATA_W,
  parameter int LEN_W  = ibuf_pkg::IBUF_LEN_W
) ();

  // descriptor
  logic              desc_valid;
  logic              desc_ready;
  logic [ADDR_W-1:0] desc_addr;
  logic [LEN_W-1:0]  desc_len;

  // buffer port a requests and returns
  logic              ibuf_cen;
  logic              ibuf_wen;
  logic              ibuf_last;
  logic [ADDR_W-1:0] ibuf_addr;
  logic              ibuf_ready;
  logic [DATA_W-1:0] ibuf_rdata;
  logic              ibuf_rvalid;
  logic              ibuf_rlast;
  logic              ibuf_rready;

  // output stream
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;

  // burst generator side
  modport master (
    input  desc_valid, desc_addr, desc_len,
    input  ibuf_ready, ibuf_rdata, ibuf_rvalid, ibuf_rlast,
    input  m_ready,
    output desc_ready,
    output ibuf_cen, ibuf_wen, ibuf_last, ibuf_addr, ibuf_rready,
    output m_valid, m_data, m_last
  );

  // descriptor source, buffer and stream consumer side
  modport slave (
    output desc_valid, desc_addr, desc_len,
    output ibuf_ready, ibuf_rdata, ibuf_rvalid, ibuf_rlast,
    output m_ready,
    input  desc_ready,
    input  ibuf_cen, ibuf_wen, ibuf_last, ibuf_addr, ibuf_rready,
    input  m_valid, m_data, m_last
  );

endinterface

// File: rtl/ibuffer_rd_burst_gen_fwdbwd_pipe.sv
// Full-throughput register slice with registered valid/data and registered ready.
// Latency: one cycle from in_valid to out_valid.
// Backpressure: a skid entry absorbs the beat in flight; in_ready drops once it is used.
module fwdbwd_pipe #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  logic              out_vld_q, out_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic              in_rdy_q;
  logic [DATA_W-1:0] out_dat_q;
  logic [DATA_W-1:0] skid_dat_q;
  logic              in_fire;
  logic              out_free;

  assign in_fire  = in_valid && in_rdy_q;
  assign out_free = out_ready || !out_vld_q;

  // Occupancy update: output register refills from skid first, else from the input.
  always_comb begin
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (out_free) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d  = in_fire;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
    end
  end

  // Control registers; ready is low during reset and tracks skid emptiness after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= !skid_vld_d;
    end
  end

  // Data registers follow the same steering as the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_dat_q  <= '0;
      skid_dat_q <= '0;
    end else begin
      if (out_free) begin
        if (skid_vld_q) begin
          out_dat_q <= skid_dat_q;
        end else if (in_fire) begin
          out_dat_q <= in_data;
        end
      end else if (in_fire) begin
        skid_dat_q <= in_data;
      end
    end
  end

  assign in_ready  = in_rdy_q;
  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;

endmodule

// File: rtl/ibuffer_rd_burst_gen.sv
// Burst read master for ibuffer port a: one descriptor -> sequential reads -> stream.
// Latency: requests start the cycle after accept; data reaches m_* one cycle after rvalid.
// Backpressure: m_ready stalls the slice, which stalls rready; requests cap at MAX_OUTSTANDING.
// Optional stall counter output perf_stall_cnt when IBUF_RD_PERF_CNT_EN is defined.
module ibuffer_rd_burst_gen
  import ibuf_pkg::*;
#(
  parameter int ADDR_W          = IBUF_ADDR_W,
  parameter int DATA_W          = IBUF_DATA_W,
  parameter int LEN_W           = IBUF_LEN_W,
  parameter int DEPTH           = IBUF_DEPTH,
  parameter int MAX_OUTSTANDING = IBUF_MAX_OUTSTANDING
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ibuffer_rd_burst_gen_if.master bus,
  output logic                   busy,
  output logic                   done,
`ifdef IBUF_RD_PERF_CNT_EN
  output logic [31:0]            perf_stall_cnt,
`endif
  output logic                   err
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  ibuf_rd_state_e    state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  req_cnt_q;
  logic [LEN_W-1:0]  ret_cnt_q;
  logic [OUT_W-1:0]  outst_q;
  logic              err_q;
  logic              zero_done_q;
  logic              init_q;

  logic              desc_fire;
  logic              cen;
  logic              req_fire;
  logic              ret_fire;
  logic              ret_last;
  logic              m_fire_last;
  logic              slice_in_rdy;
  logic              slice_out_vld;
  logic [DATA_W:0]   slice_out_dat;

  assign desc_fire   = bus.desc_valid && bus.desc_ready;
  assign cen         = (state_q == ISSUE) && (outst_q < OUT_W'(MAX_OUTSTANDING));
  assign req_fire    = cen && bus.ibuf_ready;
  assign ret_fire    = bus.ibuf_rvalid && slice_in_rdy;
  assign ret_last    = (ret_cnt_q == LEN_W'(1));
  assign m_fire_last = slice_out_vld && bus.m_ready && slice_out_dat[DATA_W];

  // Next state: IDLE waits for a non-empty burst, ISSUE ends on the last request,
  // DRAIN ends when the last beat leaves the output slice.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (desc_fire && (bus.desc_len != '0)) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (req_fire && (req_cnt_q == LEN_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (m_fire_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; init_q holds desc_ready low until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  // Request address and the two beat counters (requests left, returns left).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      req_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else if (desc_fire) begin
      addr_q    <= bus.desc_addr;
      req_cnt_q <= bus.desc_len;
      ret_cnt_q <= bus.desc_len;
    end else begin
      if (req_fire) begin
        addr_q    <= (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
        req_cnt_q <= req_cnt_q - 1'b1;
      end
      if (ret_fire && (ret_cnt_q != '0)) begin
        ret_cnt_q <= ret_cnt_q - 1'b1;
      end
    end
  end

  // Requests accepted by the buffer whose data has not yet entered the slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q <= '0;
    end else begin
      case ({req_fire, ret_fire})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
    end
  end

  // Sticky rlast mismatch flag and the delayed done for empty bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= desc_fire && (bus.desc_len == '0);
      if (desc_fire) begin
        err_q <= 1'b0;
      end else if (ret_fire && (bus.ibuf_rlast != ret_last)) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef IBUF_RD_PERF_CNT_EN
  logic [31:0] perf_q;

  // Saturating count of ISSUE cycles lost to buffer backpressure or the outstanding cap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (desc_fire) begin
      perf_q <= '0;
    end else if ((state_q == ISSUE) &&
                 ((cen && !bus.ibuf_ready) || (outst_q == OUT_W'(MAX_OUTSTANDING))) &&
                 (perf_q != '1)) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

  // Returned data plus its computed last flag travel through the slice together.
  fwdbwd_pipe #(
    .DATA_W (DATA_W + 1)
  ) u_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.ibuf_rvalid),
    .in_ready  (slice_in_rdy),
    .in_data   ({ret_last, bus.ibuf_rdata}),
    .out_valid (slice_out_vld),
    .out_data  (slice_out_dat),
    .out_ready (bus.m_ready)
  );

  assign bus.desc_ready  = (state_q == IDLE) && init_q;
  assign bus.ibuf_cen    = cen;
  assign bus.ibuf_wen    = 1'b0;
  assign bus.ibuf_last   = cen && (req_cnt_q == LEN_W'(1));
  assign bus.ibuf_addr   = addr_q;
  assign bus.ibuf_rready = slice_in_rdy;
  assign bus.m_valid     = slice_out_vld;
  assign bus.m_data      = slice_out_dat[DATA_W-1:0];
  assign bus.m_last      = slice_out_dat[DATA_W];

  assign busy = (state_q != IDLE);
  assign done = ((state_q == DRAIN) && m_fire_last) || zero_done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ibuffer_rd_burst_gen.sv
// Directed bench: burst vectors table plus empty-burst and mid-burst reset sequences.
// A behavioural buffer returns each accepted read one cycle later.
// Stream stalls and buffer-ready gaps exercise the backpressure paths.
module tb_ibuffer_rd_burst_gen;

  localparam int DEPTH = 24576;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done, err;
`ifdef IBUF_RD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  ibuffer_rd_burst_gen_if bus ();

  ibuffer_rd_burst_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
`ifdef IBUF_RD_PERF_CNT_EN
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .err            (err)
  );

  typedef struct {
    logic [14:0] addr;
    logic        last;
  } req_t;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    logic [14:0]      addr;
    int               len;
    int               stall;
    int               inj;
    int               rmode;
    logic [3:0][14:0] exp4;
    logic             exp_err;
  } vec_t;

  req_t  q[$];
  req_t  req_log[$];
  beat_t m_log[$];
  int    ret_total  = 0;
  int    inj_target = -1;
  int    ready_mode = 0;
  int    mcyc       = 0;
  int    done_cnt   = 0;
  int    checks     = 0;
  int    failures   = 0;

  function automatic logic [127:0] beat_data(input logic [14:0] a);
    return {32'hC0DE_0000 | 32'(a), 64'h0123_4567_89AB_CDEF, 17'h0, a};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Buffer model: present the oldest accepted read, retire it on rready, log new requests.
  always @(negedge clk) begin
    mcyc++;
    if (!rst_n) begin
      q.delete();
      bus.ibuf_ready  = 1'b0;
      bus.ibuf_rvalid = 1'b0;
      bus.ibuf_rdata  = '0;
      bus.ibuf_rlast  = 1'b0;
    end else begin
      bus.ibuf_ready = (ready_mode == 0) ? 1'b1 : ((mcyc % 3) != 0);
      if (q.size() > 0) begin
        bus.ibuf_rvalid = 1'b1;
        bus.ibuf_rdata  = beat_data(q[0].addr);
        bus.ibuf_rlast  = (inj_target >= 0) ? (ret_total == inj_target) : q[0].last;
      end else begin
        bus.ibuf_rvalid = 1'b0;
        bus.ibuf_rdata  = '0;
        bus.ibuf_rlast  = 1'b0;
      end
      if (bus.ibuf_rvalid && bus.ibuf_rready) begin
        void'(q.pop_front());
        ret_total++;
      end
      if (bus.ibuf_cen && bus.ibuf_ready) begin
        q.push_back('{bus.ibuf_addr, bus.ibuf_last});
        req_log.push_back('{bus.ibuf_addr, bus.ibuf_last});
      end
    end
  end

  // Stream and done monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_valid && bus.m_ready) m_log.push_back('{bus.m_data, bus.m_last});
      if (done) done_cnt++;
    end
  end

  task automatic run_vector(input vec_t v);
    int rb, mb, db, cyc, maxq, n4;
    logic [14:0] ea;
    @(posedge clk); #1;
    rb = req_log.size();
    mb = m_log.size();
    db = done_cnt;
    inj_target = (v.inj >= 0) ? ret_total + v.inj : -1;
    ready_mode = v.rmode;
    check("desc_ready_idle", bus.desc_ready, 1);
    bus.desc_valid = 1'b1;
    bus.desc_addr  = v.addr;
    bus.desc_len   = 16'(v.len);
    bus.m_ready    = (v.stall == 0);
    @(posedge clk); #1;
    bus.desc_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("err_clear_on_accept", err, 0);
    cyc  = 0;
    maxq = 0;
    while (done_cnt == db && cyc < 400) begin
      if (q.size() > maxq) maxq = q.size();
      if (v.stall > 0 && cyc == v.stall - 1) begin
        check("reqs_during_stall", req_log.size() - rb, 6);
        check("no_beats_during_stall", m_log.size() - mb, 0);
      end
      if (cyc == v.stall) bus.m_ready = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check("burst_timeout", cyc < 400, 1);
    @(posedge clk); #1;
    check("done_once", done_cnt - db, 1);
    check("busy_end", busy, 0);
    check("err_end", err, v.exp_err);
    check("req_count", req_log.size() - rb, v.len);
    check("beat_count", m_log.size() - mb, v.len);
    check("outstanding_cap", maxq <= 4, 1);
    if (v.stall > 0) check("outstanding_reached", maxq, 4);
    n4 = (v.len < 4) ? v.len : 4;
    for (int i = 0; i < n4; i++) begin
      if (rb + i < req_log.size()) check("req_addr_table", req_log[rb+i].addr, v.exp4[i]);
    end
    for (int i = 0; i < v.len; i++) begin
      ea = 15'((int'(v.addr) + i) % DEPTH);
      if (rb + i < req_log.size()) begin
        check("req_addr", req_log[rb+i].addr, ea);
        check("req_last", req_log[rb+i].last, i == v.len - 1);
      end
      if (mb + i < m_log.size()) begin
        check("m_data", m_log[mb+i].data, beat_data(ea));
        check("m_last", m_log[mb+i].last, i == v.len - 1);
      end
    end
    inj_target = -1;
    ready_mode = 0;
  endtask

  vec_t vecs[6];

  initial begin
    int rb, db, cyc;
    logic bad;
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, db, cyc;
    logic bad;
    vecs[0] = '{15'h0010, 4, 0, -1, 0, {15'h0013, 15'h0012, 15'h0011, 15'h0010}, 1'b0};
    vecs[1] = '{15'h5FFE, 4, 0, -1, 0, {15'h0001, 15'h0000, 15'h5FFF, 15'h5FFE}, 1'b0};
    vecs[2] = '{15'h0100, 8, 20, -1, 0, {15'h0103, 15'h0102, 15'h0101, 15'h0100}, 1'b0};
    vecs[3] = '{15'h0020, 3, 0, 1, 0, {15'h0000, 15'h0022, 15'h0021, 15'h0020}, 1'b1};
    vecs[4] = '{15'h5FFF, 1, 0, -1, 0, {15'h0000, 15'h0000, 15'h0000, 15'h5FFF}, 1'b0};
    vecs[5] = '{15'h0040, 6, 0, -1, 1, {15'h0043, 15'h0042, 15'h0041, 15'h0040}, 1'b0};

    bus.desc_valid = 1'b0;
    bus.desc_addr  = '0;
    bus.desc_len   = '0;
    bus.m_ready    = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_desc_ready", bus.desc_ready, 0);
    check("rst_cen", bus.ibuf_cen, 0);
    check("rst_rready", bus.ibuf_rready, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vector(vecs[i]);

    // empty burst: accepted, done next cycle, no requests, never busy
    @(posedge clk); #1;
    rb = req_log.size();
    db = done_cnt;
    check("zero_desc_ready", bus.desc_ready, 1);
    bus.desc_valid = 1'b1;
    bus.desc_addr  = 15'h0005;
    bus.desc_len   = 16'd0;
    @(posedge clk); #1;
    bus.desc_valid = 1'b0;
    check("zero_done_pulse", done, 1);
    check("zero_busy", busy, 0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (busy || bus.ibuf_cen || done) bad = 1'b1;
    end
    check("zero_quiet", bad, 0);
    check("zero_no_reqs", req_log.size() - rb, 0);
    check("zero_done_count", done_cnt - db, 1);

    // reset while the third request of a len=8 burst is on the bus
    @(posedge clk); #1;
    bus.desc_valid = 1'b1;
    bus.desc_addr  = 15'h0200;
    bus.desc_len   = 16'd8;
    bus.m_ready    = 1'b1;
    @(posedge clk); #1;
    bus.desc_valid = 1'b0;
    rb  = req_log.size() - 0;
    cyc = 0;
    while (!((req_log.size() - rb == 2) && bus.ibuf_cen) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_wait_timeout", cyc < 50, 1);
    rst_n = 1'b0;
    #1;
    check("arst_cen", bus.ibuf_cen, 0);
    check("arst_last", bus.ibuf_last, 0);
    check("arst_addr", bus.ibuf_addr, 0);
    check("arst_rready", bus.ibuf_rready, 0);
    check("arst_m_valid", bus.m_valid, 0);
    check("arst_m_data", bus.m_data, 0);
    check("arst_m_last", bus.m_last, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_desc_ready", bus.desc_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin
      vec_t v;
      v = '{15'h0300, 2, 0, -1, 0, {15'h0000, 15'h0000, 15'h0301, 15'h0300}, 1'b0};
      run_vector(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
